// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha20 block-function core.
package chacha_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [3:0][3:0] matrix_t;

    // Micro-step of the serial ARX sequence; IDLE waits for a new block.
    typedef enum logic [3:0] {
        IDLE, S0, S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12
    } arx_state_t;

    // Quarter-round selector: Q0..Q3 are columns, Q4..Q7 are diagonals.
    typedef enum logic [2:0] {
        Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7
    } q_state_t;

    localparam int ROT_16 = 16;
    localparam int ROT_12 = 12;
    localparam int ROT_8  = 8;
    localparam int ROT_7  = 7;
    localparam int ROUNDS = 10;

    // 32-bit rotate left by a constant amount.
    function automatic word_t rotl(word_t x, int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Column of operand k (row k) for quarter-round q. Columns select a
    // fixed column; diagonals walk one column right per row, wrapping.
    function automatic logic [1:0] qcol(q_state_t q, logic [1:0] k);
        logic [2:0] qv;
        qv = 3'(q);
        if (!qv[2]) begin
            return qv[1:0];
        end
        return qv[1:0] + k;
    endfunction

endpackage

// File: rtl/chacha_arx_step.sv
// One ARX micro-operation of the quarter-round, selected by the step state.
module chacha_arx_step
    import chacha_pkg::*;
(
    input  arx_state_t step,
    input  word_t      a,
    input  word_t      b,
    input  word_t      c,
    input  word_t      d,
    output word_t      a_next,
    output word_t      b_next,
    output word_t      c_next,
    output word_t      d_next
);

    // Apply the single add, xor or rotate for this step; others pass through.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        a_next = a;
        b_next = b;
        c_next = c;
        d_next = d;
        unique case (step)
            S0:      a_next = a + b;
            S1:      d_next = d ^ a;
            S2:      d_next = rotl(d, ROT_16);
            S3:      c_next = c + d;
            S4:      b_next = b ^ c;
            S5:      b_next = rotl(b, ROT_12);
            S6:      a_next = a + b;
            S7:      d_next = d ^ a;
            S8:      d_next = rotl(d, ROT_8);
            S9:      c_next = c + d;
            S10:     b_next = b ^ c;
            S11:     b_next = rotl(b, ROT_7);
            default: ;
        endcase
    end

endmodule

// File: rtl/perform_qround.sv
// ChaCha20 block function: 80 quarter-rounds run serially, one ARX step per
// clock, followed by the feed-forward addition of the latched input.
module perform_qround
    import chacha_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              setRounds,
    input  word_t [3:0][3:0]  chachamatrixIN,
    output word_t [3:0][3:0]  chachamatrixOUT,
    output logic              blockready,
    output logic [3:0]        blocksproduced
);

    matrix_t    init_m;
    matrix_t    w;
    word_t      a, b, c, d;
    arx_state_t curr_step, step_nxt;
    q_state_t   curr_q, q_nxt;
    logic [3:0] round_cnt, round_nxt;
    logic       done, done_nxt;

    matrix_t    w_wb;
    matrix_t    block_sum;
    q_state_t   q_seq;
    q_state_t   sel_q;
    logic       last_qr;
    logic       finish;
    word_t      op_a, op_b, op_c, op_d;
    word_t      arx_a, arx_b, arx_c, arx_d;

    chacha_arx_step u_arx (
        .step   (curr_step),
        .a      (a),
        .b      (b),
        .c      (c),
        .d      (d),
        .a_next (arx_a),
        .b_next (arx_b),
        .c_next (arx_c),
        .d_next (arx_d)
    );

    assign q_seq   = q_state_t'(3'(curr_q) + 3'd1);
    assign last_qr = (curr_q == Q7) && (round_cnt == 4'(ROUNDS - 1));

    // Working matrix as it looks after this cycle's write-back (if any).
    always_comb begin
        w_wb = w;
        if (curr_step == S12) begin
            w_wb[0][qcol(curr_q, 2'd0)] = a;
            w_wb[1][qcol(curr_q, 2'd1)] = b;
            w_wb[2][qcol(curr_q, 2'd2)] = c;
            w_wb[3][qcol(curr_q, 2'd3)] = d;
        end
    end

    // Operand fetch: at write-back, fetch the next quarter-round's words from
    // the forwarded matrix so no idle cycle is needed between quarter-rounds.
    always_comb begin
        sel_q = (curr_step == S12) ? q_seq : curr_q;
        op_a  = w_wb[0][qcol(sel_q, 2'd0)];
        op_b  = w_wb[1][qcol(sel_q, 2'd1)];
        op_c  = w_wb[2][qcol(sel_q, 2'd2)];
        op_d  = w_wb[3][qcol(sel_q, 2'd3)];
    end

    // Feed-forward: final working state plus the original input.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                block_sum[i][j] = w_wb[i][j] + init_m[i][j];
            end
        end
    end

    // Next-state logic for step, quarter-round, round and done.
    always_comb begin
        step_nxt  = curr_step;
        q_nxt     = curr_q;
        round_nxt = round_cnt;
        done_nxt  = done;
        finish    = 1'b0;
        if (setRounds) begin
            step_nxt  = IDLE;
            q_nxt     = Q0;
            round_nxt = 4'd0;
            done_nxt  = 1'b0;
        end else begin
            unique case (curr_step)
                IDLE: begin
                    if (!done) begin
                        step_nxt = S0;
                    end
                end
                S12: begin
                    if (last_qr) begin
                        step_nxt  = IDLE;
                        q_nxt     = Q0;
                        round_nxt = 4'd0;
                        done_nxt  = 1'b1;
                        finish    = 1'b1;
                    end else begin
                        step_nxt = S0;
                        q_nxt    = q_seq;
                        if (curr_q == Q7) begin
                            round_nxt = round_cnt + 4'd1;
                        end
                    end
                end
                default: step_nxt = arx_state_t'(4'(curr_step) + 4'd1);
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curr_step <= IDLE;
            curr_q    <= Q0;
            round_cnt <= 4'd0;
            done      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            curr_step <= step_nxt;
            curr_q    <= q_nxt;
            round_cnt <= round_nxt;
            done      <= done_nxt;
        end
    end

    // Datapath: input latch, operand registers, working matrix and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the matrices are flops, not RAM, so clearing them on reset is intended.
            init_m          <= '0;
            w               <= '0;
            a               <= '0;
            b               <= '0;
            c               <= '0;
            d               <= '0;
            chachamatrixOUT <= '0;
            blockready      <= 1'b0;
            blocksproduced  <= 4'd0;
        end else begin
            blockready <= 1'b0;
            if (setRounds) begin
                init_m <= chachamatrixIN;
                w      <= chachamatrixIN;
            end else begin
                unique case (curr_step)
                    IDLE: begin
                        if (!done) begin
                            a <= op_a;
                            b <= op_b;
                            c <= op_c;
                            d <= op_d;
                        end
                    end
                    S12: begin
                        w <= w_wb;
                        a <= op_a;
                        b <= op_b;
                        c <= op_c;
                        d <= op_d;
                        if (finish) begin
                            chachamatrixOUT <= block_sum;
                            blockready      <= 1'b1;
                            blocksproduced  <= blocksproduced + 4'd1;
                        end
                    end
                    default: begin
                        a <= arx_a;
                        b <= arx_b;
                        c <= arx_c;
                        d <= arx_d;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_perform_qround.sv
// Self-checking bench for perform_qround: RFC 7539 vector with per-step
// tracking, abort, async reset mid-run and the block counter wrap.
module tb_perform_qround;
    import chacha_pkg::*;

    typedef word_t flat_t [16];
    typedef struct {
        matrix_t    out;
        logic [3:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       setRounds = 1'b0;
    matrix_t    m_in = '0;
    matrix_t    m_out;
    logic       blockready;
    logic [3:0] blocksproduced;

    int         total = 0;
    int         bad = 0;
    int         pulses = 0;
    exp_t       sb[$];
    logic [3:0] exp_cnt = 4'd0;

    // Operand indices (row*4+col) for each quarter-round: columns then diagonals.
    int qtab [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                        '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};

    perform_qround dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .setRounds       (setRounds),
        .chachamatrixIN  (m_in),
        .chachamatrixOUT (m_out),
        .blockready      (blockready),
        .blocksproduced  (blocksproduced)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic word_t rol(word_t v, int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic matrix_t to_m(flat_t x);
        matrix_t r;
        for (int i = 0; i < 16; i++) r[i / 4][i % 4] = x[i];
        return r;
    endfunction

    function automatic matrix_t rand_m();
        matrix_t r;
        for (int i = 0; i < 16; i++) r[i / 4][i % 4] = $urandom;
        return r;
    endfunction

    // Reference ChaCha20 block function on a flat 16-word state.
    function automatic matrix_t model_block(matrix_t m);
        word_t   x[16];
        word_t   s[16];
        matrix_t r;
        for (int i = 0; i < 16; i++) begin
            x[i] = m[i / 4][i % 4];
            s[i] = x[i];
        end
        for (int rd = 0; rd < 10; rd++) begin
            for (int q = 0; q < 8; q++) begin
                int ia, ib, ic, id;
                ia = qtab[q][0]; ib = qtab[q][1]; ic = qtab[q][2]; id = qtab[q][3];
                x[ia] = x[ia] + x[ib]; x[id] = rol(x[id] ^ x[ia], 16);
                x[ic] = x[ic] + x[id]; x[ib] = rol(x[ib] ^ x[ic], 12);
                x[ia] = x[ia] + x[ib]; x[id] = rol(x[id] ^ x[ia], 8);
                x[ic] = x[ic] + x[id]; x[ib] = rol(x[ib] ^ x[ic], 7);
            end
        end
        for (int i = 0; i < 16; i++) r[i / 4][i % 4] = x[i] + s[i];
        return r;
    endfunction

    // Load a matrix with a one-cycle setRounds pulse, release, and expect its block.
    task automatic start_block(input matrix_t m, input matrix_t expected);
        exp_t e;
        setRounds = 1'b1;
        m_in      = m;
        tick();
        setRounds = 1'b0;
        exp_cnt   = exp_cnt + 4'd1;
        e.out     = expected;
        e.cnt     = exp_cnt;
        sb.push_back(e);
    endtask

    // Scoreboard consumer: every blockready pulse must match the oldest expectation.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (blockready === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                check("blockready_unexpected", 512'(blockready), 512'(0));
            end else begin
                e = sb.pop_front();
                check("block_out", m_out, e.out);
                check("blocksproduced", 512'(blocksproduced), 512'(e.cnt));
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        flat_t   rfc_flat;
        flat_t   x;
        matrix_t rfc_in, rfc_out, m;
        word_t   ma, mb, mc, md;
        int      q, p0;

        rfc_flat = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
                     32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                     32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                     32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
        rfc_in   = to_m(rfc_flat);
        rfc_flat = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
                     32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
                     32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
                     32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};
        rfc_out  = to_m(rfc_flat);

        // Reset with random inputs.
        setRounds = 1'($urandom);
        m_in      = rand_m();
        tick();
        tick();
        check("rst_out", m_out, '0);
        check("rst_blockready", 512'(blockready), 512'(0));
        check("rst_blocksproduced", 512'(blocksproduced), 512'(0));
        check("rst_step", 512'(dut.curr_step), 512'(IDLE));
        setRounds = 1'b1;
        rst_n     = 1'b1;
        tick();

        // RFC 7539 vector with per-step tracking of a..d and W.
        p0 = pulses;
        start_block(rfc_in, rfc_out);
        x = '{default: '0};
        for (int i = 0; i < 16; i++) x[i] = rfc_in[i / 4][i % 4];
        tick();  // edge 1: IDLE -> S0, operands of Q0 loaded
        for (int qr = 0; qr < 80; qr++) begin
            q  = qr % 8;
            ma = x[qtab[q][0]]; mb = x[qtab[q][1]]; mc = x[qtab[q][2]]; md = x[qtab[q][3]];
            check($sformatf("load_qr%0d", qr), {dut.a, dut.b, dut.c, dut.d}, {ma, mb, mc, md});
            for (int s = 0; s < 12; s++) begin
                tick();
                case (s)
                    0, 6:  ma = ma + mb;
                    1, 7:  md = md ^ ma;
                    2:     md = {md[15:0], md[31:16]};
                    3, 9:  mc = mc + md;
                    4, 10: mb = mb ^ mc;
                    5:     mb = {mb[19:0], mb[31:20]};
                    8:     md = {md[23:0], md[31:24]};
                    default: mb = {mb[24:0], mb[31:25]};
                endcase
                check($sformatf("step_qr%0d_s%0d", qr, s), {dut.a, dut.b, dut.c, dut.d},
                      {ma, mb, mc, md});
            end
            tick();  // S12 write-back
            x[qtab[q][0]] = ma; x[qtab[q][1]] = mb; x[qtab[q][2]] = mc; x[qtab[q][3]] = md;
            check($sformatf("wb_qr%0d", qr), dut.w, to_m(x));
            if (qr < 79) check($sformatf("early_ready_qr%0d", qr), 512'(blockready), 512'(0));
        end
        check("rfc_ready_1041", 512'(blockready), 512'(1));
        check("rfc_pulses", 512'(pulses), 512'(p0 + 1));
        check("rfc_out_direct", m_out, rfc_out);
        tick();
        check("rfc_ready_one_cycle", 512'(blockready), 512'(0));
        repeat (20) tick();
        check("done_hold_pulses", 512'(pulses), 512'(p0 + 1));
        check("done_hold_step", 512'(dut.curr_step), 512'(IDLE));
        check("out_held", m_out, rfc_out);

        // Abort with a setRounds pulse at cycle 500, then a clean block.
        m  = rand_m();
        p0 = pulses;
        start_block(m, model_block(m));
        repeat (499) tick();
        void'(sb.pop_back());
        exp_cnt = exp_cnt - 4'd1;
        start_block(m, model_block(m));
        repeat (1040) tick();
        check("abort_no_pulse", 512'(pulses), 512'(p0));
        check("abort_count_held", 512'(blocksproduced), 512'(2'd1));
        tick();
        check("abort_ready_after_release", 512'(blockready), 512'(1));
        check("abort_pulses", 512'(pulses), 512'(p0 + 1));

        // Async reset at cycle 300 of a run.
        m = rand_m();
        start_block(m, model_block(m));
        repeat (300) tick();
        rst_n     = 1'b0;
        setRounds = 1'b1;
        sb.delete();
        exp_cnt   = 4'd0;
        p0        = pulses;
        #1;
        check("arst_out", m_out, '0);
        check("arst_blocksproduced", 512'(blocksproduced), 512'(0));
        check("arst_step", 512'(dut.curr_step), 512'(IDLE));
        check("arst_w", dut.w, '0);
        tick();
        rst_n = 1'b1;
        repeat (1100) tick();
        check("arst_no_pulse", 512'(pulses), 512'(p0));

        // 17 back-to-back blocks: counter runs 1..15, 0, 1.
        for (int k = 0; k < 17; k++) begin
            m  = rand_m();
            p0 = pulses;
            start_block(m, model_block(m));
            repeat (1040) tick();
            check($sformatf("cnt_blk%0d_no_early", k), 512'(pulses), 512'(p0));
            tick();
            check($sformatf("cnt_blk%0d_ready", k), 512'(blockready), 512'(1));
            check($sformatf("cnt_blk%0d_pulses", k), 512'(pulses), 512'(p0 + 1));
            check($sformatf("cnt_blk%0d_value", k), 512'(blocksproduced), 512'((k + 1) % 16));
        end
        tick();
        check("scoreboard_drained", 512'(sb.size()), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
